// File: rtl/poly_pkg.sv
// Shared parameters, FSM encoding and operand-pair payload for the polynomial add sequencer.
package poly_pkg;

    localparam int unsigned Q      = 17;
    localparam int unsigned N      = 8;
    localparam int unsigned LOGQ   = 5;
    localparam int unsigned LOGN   = 3;
    localparam int unsigned CNT_W  = LOGN + 1;
    localparam int unsigned PAIR_W = 2 * LOGQ;

    typedef logic [LOGQ-1:0]  coef_t;
    typedef logic [LOGN-1:0]  idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        coef_t a;
        coef_t b;
    } pair_t;

endpackage

// File: rtl/poly_add_sequencer_if.sv
// Request, operand-RAM, adder and result-RAM signals of the polynomial add sequencer.
interface poly_add_sequencer_if;
    import poly_pkg::*;

    logic  start;
    logic  busy;
    logic  done;
    logic  rd_en;
    idx_t  rd_addr;
    coef_t rd_data0;
    coef_t rd_data1;
    logic  add_in0_valid;
    logic  add_in1_valid;
    coef_t add_in0;
    coef_t add_in1;
    logic  add_in_ready;
    logic  add_out_valid;
    coef_t add_out;
    logic  add_out_ready;
    logic  wr_en;
    idx_t  wr_addr;
    coef_t wr_data;

    modport master (
        input  start, rd_data0, rd_data1, add_in_ready, add_out_valid, add_out,
        output busy, done, rd_en, rd_addr, add_in0_valid, add_in1_valid,
               add_in0, add_in1, add_out_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, rd_data0, rd_data1, add_in_ready, add_out_valid, add_out,
        input  busy, done, rd_en, rd_addr, add_in0_valid, add_in1_valid,
               add_in0, add_in1, add_out_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/poly_pair_fifo.sv
// Two-entry FIFO holding operand pairs between the RAM read port and the adder.
module poly_pair_fifo
    import poly_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       push,
    input  pair_t      push_data,
    input  logic       pop,
    output pair_t      head,
    output logic       not_empty,
    output logic [1:0] count
);

    pair_t mem [2];
    logic  wr_ptr;
    logic  rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // Payload storage needs no reset; occupancy gates its visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head      = mem[rd_ptr];
    assign not_empty = (count != 2'd0);

endmodule

// File: rtl/poly_add_sequencer.sv
// Streams N coefficient pairs from two operand RAMs through an external modular adder into a result RAM.
module poly_add_sequencer
    import poly_pkg::*;
(
    input logic                   clk,
    input logic                   reset,
    poly_add_sequencer_if.master  bus
);

    state_t     state;
    cnt_t       rd_idx;
    cnt_t       wr_cnt;
    logic       rd_pend;
    logic       fifo_clear;
    logic       fifo_ne;
    logic       pop;
    logic [1:0] occ;
    logic [2:0] outstanding;
    logic       run;
    logic       rd_en;
    logic       wr_en;
    pair_t      head;

    assign run        = (state == RUN);
    assign fifo_clear = (state == IDLE) && bus.start;
    assign pop        = fifo_ne && bus.add_in_ready;

    // Credit check counts the slot freed by this cycle's pop so reads can stream back to back.
    assign outstanding = 3'(occ) + 3'(rd_pend) - 3'(pop);
    assign rd_en       = run && (rd_idx < CNT_W'(N)) && (outstanding < 3'd2);
    assign wr_en       = bus.add_out_valid && run;

    poly_pair_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (fifo_clear),
        .push      (rd_pend),
        .push_data ('{a: bus.rd_data0, b: bus.rd_data1}),
        .pop       (pop),
        .head      (head),
        .not_empty (fifo_ne),
        .count     (occ)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rd_idx  <= '0;
            wr_cnt  <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= rd_en;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= RUN;
                        rd_idx  <= '0;
                        wr_cnt  <= '0;
                        rd_pend <= 1'b0;
                    end
                end
                RUN: begin
                    if (rd_en) rd_idx <= rd_idx + CNT_W'(1);
                    if (wr_en) begin
                        wr_cnt <= wr_cnt + CNT_W'(1);
                        if (wr_cnt == CNT_W'(N - 1)) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy          = (state != IDLE);
    assign bus.done          = (state == DONE);
    assign bus.rd_en         = rd_en;
    assign bus.rd_addr       = rd_idx[LOGN-1:0];
    assign bus.add_in0_valid = fifo_ne;
    assign bus.add_in1_valid = fifo_ne;
    assign bus.add_in0       = head.a;
    assign bus.add_in1       = head.b;
    assign bus.add_out_ready = run;
    assign bus.wr_en         = wr_en;
    assign bus.wr_addr       = wr_cnt[LOGN-1:0];
    assign bus.wr_data       = bus.add_out;

endmodule

// File: tb/tb_poly_add_sequencer.sv
// Scoreboard bench: operand RAM and adder models feed the sequencer; a monitor checks each result write.
module tb_poly_add_sequencer;
    import poly_pkg::*;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    poly_add_sequencer_if bus();

    poly_add_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    coef_t mem_a [N];
    coef_t mem_b [N];
    exp_t  sb [$];
    int    checks     = 0;
    int    failures   = 0;
    int    cyc        = 0;
    int    ready_mode = 3;
    int    phase      = 0;
    int    wr_seen    = 0;
    int    done_cnt   = 0;
    int    first_wr   = -1;
    int    start_cyc  = 0;
    int    occ        = 0;
    int    prev_rd    = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Operand RAMs: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data0 <= mem_a[bus.rd_addr];
            bus.rd_data1 <= mem_b[bus.rd_addr];
        end
    end

    // Combinational mod-q adder that accepts whenever it is ready.
    assign bus.add_out_valid = bus.add_in0_valid && bus.add_in_ready;
    assign bus.add_out = coef_t'((int'(bus.add_in0) + int'(bus.add_in1)) % int'(Q));

    always @(posedge clk) begin
        #1;
        phase++;
        case (ready_mode)
            0:       bus.add_in_ready = 1'b1;
            1:       bus.add_in_ready = (phase % 4 == 0) || (phase % 4 == 3);
            2:       bus.add_in_ready = 1'($urandom_range(0, 1));
            default: bus.add_in_ready = 1'b0;
        endcase
    end

    // Monitor: FIFO occupancy tracking and result scoreboard.
    always @(negedge clk) begin
        int pop;
        exp_t e;
        if (reset) begin
            occ     = 0;
            prev_rd = 0;
        end else begin
            pop = int'(bus.add_in0_valid && bus.add_in_ready);
            if (bus.busy) check("fifo_occupancy_in_range", int'(occ >= 0 && occ <= 2), 1);
            if (bus.add_in0_valid || bus.add_in1_valid)
                check("add_valid_equal", int'(bus.add_in0_valid), int'(bus.add_in1_valid));
            occ     = occ + prev_rd - pop;
            prev_rd = int'(bus.rd_en);
            if (bus.wr_en) begin
                wr_seen++;
                if (first_wr < 0) first_wr = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", int'(bus.wr_addr), e.addr);
                    check("wr_data", int'(bus.wr_data), e.data);
                end
            end
            if (bus.done) done_cnt++;
        end
    end

    task automatic load(input int fill);
        int x;
        for (int i = 0; i < int'(N); i++) begin
            case (fill)
                0: begin mem_a[i] = coef_t'(16); mem_b[i] = coef_t'(16); end
                1: begin mem_a[i] = coef_t'(i); mem_b[i] = coef_t'(16 - i); end
                3: begin
                    x = int'($urandom_range(1, 16));
                    mem_a[i] = coef_t'(x);
                    mem_b[i] = coef_t'(17 - x);
                end
                default: begin
                    mem_a[i] = coef_t'($urandom_range(0, 16));
                    mem_b[i] = coef_t'($urandom_range(0, 16));
                end
            endcase
            sb.push_back('{addr: i, data: (int'(mem_a[i]) + int'(mem_b[i])) % 17});
        end
    endtask

    task automatic run_op(input string tag, input int fill, input int rmode, input bit poke);
        bit seen;
        int lat;
        seen = 1'b0;
        lat  = 0;
        load(fill);
        ready_mode = rmode;
        wr_seen    = 0;
        done_cnt   = 0;
        first_wr   = -1;
        @(posedge clk); #1;
        bus.start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 0; c < 80 && !seen; c++) begin
            @(negedge clk); #1;
            if (poke) bus.start = (c == 3 || c == 6);
            if (bus.done) begin
                seen = 1'b1;
                lat  = cyc - start_cyc;
            end
        end
        bus.start = 1'b0;
        check({tag, "_done_seen"}, int'(seen), 1);
        if (rmode == 0) begin
            check({tag, "_done_latency_ok"}, int'(lat <= int'(N) + 4), 1);
            check({tag, "_first_write_latency_ok"},
                  int'(first_wr >= 0 && first_wr - start_cyc <= 3), 1);
        end
        @(negedge clk); #1;
        check({tag, "_busy_after_done"}, int'(bus.busy), 0);
        check({tag, "_done_cleared"}, int'(bus.done), 0);
        check({tag, "_write_count"}, wr_seen, int'(N));
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_scoreboard_drained"}, sb.size(), 0);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_rd_en", int'(bus.rd_en), 0);
        check("rst_add_valid", int'(bus.add_in0_valid), 0);
        check("rst_add_out_ready", int'(bus.add_out_ready), 0);
        check("rst_wr_en", int'(bus.wr_en), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_op("stress16", 0, 0, 1'b0);
        run_op("boundary_ramp", 1, 0, 1'b0);
        run_op("pairs_to_zero", 3, 0, 1'b0);
        run_op("backpressure", 2, 1, 1'b0);
        run_op("start_while_busy", 2, 0, 1'b1);
        run_op("random_ready_a", 2, 2, 1'b0);
        run_op("random_ready_b", 3, 2, 1'b0);

        // Abort mid-run after three writes.
        load(2);
        ready_mode = 0;
        wr_seen    = 0;
        done_cnt   = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 0; c < 40 && wr_seen < 3; c++) begin
            @(negedge clk); #1;
        end
        check("abort_three_writes", wr_seen, 3);
        reset = 1'b1;
        sb.delete();
        @(negedge clk); #1;
        check("abort_busy_low", int'(bus.busy), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        check("abort_no_more_writes", wr_seen, 3);
        check("abort_no_done", done_cnt, 0);

        run_op("after_abort", 2, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/poly_add_sequencer.md
POLY_ADD_SEQUENCER -- requirements
Module: poly_add_sequencer

Interface
REQ-001 Parameters SHALL be: q=17 (modulus, passed to the adder); N=8 (coefficients per polynomial); logq=5 (coefficient width); logN=3 (index width, 2^logN = N).
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  single-cycle request to add two stored polynomials.
REQ-005 busy  out  1  high from the accepted start until done.
REQ-006 done  out  1  one-cycle pulse after the last result write.
REQ-007 rd_en  out  1  read strobe to both operand RAMs.
REQ-008 rd_addr  out  logN  operand coefficient index.
REQ-009 rd_data0 / rd_data1  in  logq each  operand words, valid exactly 1 cycle after rd_en.
REQ-010 add_in0_valid / add_in1_valid  out  1 each  operand-valid outputs to the adder; always equal.
REQ-011 add_in0 / add_in1  out  logq each  operand pair to the adder.
REQ-012 add_in_ready  in  1  adder accepts the pair this cycle.
REQ-013 add_out_valid  in  1  adder result valid.
REQ-014 add_out  in  logq  adder result.
REQ-015 add_out_ready  out  1  result accepted by this block.
REQ-016 wr_en  out  1  result-RAM write strobe.
REQ-017 wr_addr  out  logN  result index.
REQ-018 wr_data  out  logq  result word, equal to add_out.

Function
REQ-019 FSM states SHALL be IDLE, RUN and DONE; IDLE->RUN on start, RUN->DONE when wr_cnt reaches N, DONE->IDLE unconditionally after one cycle.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 busy SHALL be high in RUN and DONE; done SHALL be high only in DONE.
REQ-022 On entering RUN, rd_idx, wr_cnt and the operand FIFO SHALL be cleared.
REQ-023 In RUN, rd_en SHALL assert when rd_idx<N and (FIFO occupancy + reads in flight) < 2; rd_addr=rd_idx; rd_idx increments on each rd_en.
REQ-024 The returning {rd_data0, rd_data1} SHALL be pushed into a 2-entry operand FIFO on the cycle after rd_en.
REQ-025 add_in*_valid SHALL equal FIFO not-empty; add_in0/add_in1 SHALL be the FIFO head; a pop occurs iff valid && add_in_ready.
REQ-026 A push and a pop in the same cycle SHALL leave occupancy unchanged; overflow SHALL be impossible by REQ-023.
REQ-027 add_out_ready SHALL be 1 in RUN and 0 otherwise; wr_en = add_out_valid && add_out_ready; wr_addr = wr_cnt; wr_data = add_out; wr_cnt increments on wr_en.
REQ-028 Operand order SHALL be preserved: the result written at address i SHALL be (a[i]+b[i]) mod q.
REQ-029 With add_in_ready continuously high, reads SHALL issue on consecutive cycles and the first write SHALL occur no later than 3 cycles after start; total start-to-done time SHALL be at most N+4 cycles.
REQ-030 Counters SHALL be logN+1 bits wide so that the value N is representable without wrap.

Reset
REQ-031 reset SHALL force state to IDLE, rd_idx=0, wr_cnt=0, FIFO empty, read-in-flight=0.
REQ-032 Reset outputs SHALL be: busy=0, done=0, rd_en=0, add_in*_valid=0, add_out_ready=0, wr_en=0.
REQ-033 Reset asserted mid-RUN SHALL abort the operation with no further writes and no done pulse.

Structure
REQ-034 The FSM state encoding SHALL reside in the shared package poly_pkg.
REQ-035 The operand FIFO SHALL be a sub-module poly_pair_fifo (depth 2, width 2*logq).

Verification
REQ-036 Stress: a=b={16,...,16}, add_in_ready=1 -> every write = 15, done at or before cycle start+12.
REQ-037 Boundary: a={0,1,...,7}, b={16,15,...,9} -> all results = 16; a[i]+b[i]=17 pairs -> 0.
REQ-038 Backpressure: add_in_ready toggled 1,0,0,1 repeating -> FIFO occupancy never exceeds 2, results correct and in address order 0..7.
REQ-039 start pulsed while busy -> ignored; exactly 8 writes and one done pulse.
REQ-040 Reset asserted after 3 writes -> busy=0 next cycle, no further wr_en, no done; a fresh start then completes normally.
